// File: rtl/vec_chk_pkg.sv
// Shared types and helpers for the exhaustive vector sweep checker.
package vec_chk_pkg;

    typedef enum logic [2:0] {
        VCHK_IDLE,
        VCHK_DRIVE,
        VCHK_SETTLE,
        VCHK_COMPARE,
        VCHK_DONE
    } vchk_state_t;

    localparam int unsigned VCHK_MIN_SETTLE = 1;

    // Number of busy cycles for one full sweep of 2^n_in vectors.
    function automatic int unsigned vchk_sweep_cycles(input int unsigned n_in,
                                                      input int unsigned settle);
        return (32'd1 << n_in) * (settle + 32'd2);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up counter that clears synchronously and holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != CNT_MAX)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vec_sweep_checker.sv
// Walks every input vector, waits a settle window, then compares golden vs
// post-route results and accumulates a mismatch count and pass verdict.
module vec_sweep_checker
    import vec_chk_pkg::*;
#(
    parameter int unsigned N_IN       = 2,
    parameter int unsigned N_OUT      = 1,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] golden_in,
    input  logic [N_OUT-1:0] netlist_in,
    output logic             busy,
    output logic             cmp_valid,
    output logic             cmp_match,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             fail_seen,
    output logic [N_IN-1:0]  first_fail_vec
);

    localparam int unsigned SETTLE_EFF = (SETTLE_CYC < VCHK_MIN_SETTLE) ?
                                         VCHK_MIN_SETTLE : SETTLE_CYC;
    localparam int unsigned SET_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [N_IN-1:0] STIM_LAST = '1;

    vchk_state_t      state_q, state_d;
    logic [N_IN-1:0]  stim_q, stim_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             busy_q, busy_d;
    logic             cmp_valid_q, cmp_valid_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_seen_q, fail_seen_d;
    logic [N_IN-1:0]  first_fail_q, first_fail_d;
    logic             cnt_clr, cnt_inc;
    logic             mismatch;

    assign mismatch = (golden_in != netlist_in);

    sat_counter #(.CNT_W(CNT_W)) u_mismatch_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .q   (mismatch_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= VCHK_IDLE;
            stim_q       <= '0;
            settle_q     <= '0;
            busy_q       <= 1'b0;
            cmp_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_seen_q  <= 1'b0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            stim_q       <= stim_d;
            settle_q     <= settle_d;
            busy_q       <= busy_d;
            cmp_valid_q  <= cmp_valid_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_seen_q  <= fail_seen_d;
            first_fail_q <= first_fail_d;
        end
    end

    // Next-state and registered-output updates; cmp_valid is registered one
    // cycle ahead so it is high exactly while the FSM sits in COMPARE.
    always_comb begin
        state_d      = state_q;
        stim_d       = stim_q;
        settle_d     = settle_q;
        busy_d       = busy_q;
        cmp_valid_d  = 1'b0;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_seen_d  = fail_seen_q;
        first_fail_d = first_fail_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;

        case (state_q)
            VCHK_IDLE, VCHK_DONE: begin
                if (start) begin
                    state_d      = VCHK_DRIVE;
                    stim_d       = '0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    fail_seen_d  = 1'b0;
                    first_fail_d = '0;
                    cnt_clr      = 1'b1;
                end
            end
            VCHK_DRIVE: begin
                settle_d = SET_W'(SETTLE_EFF - 1);
                state_d  = VCHK_SETTLE;
            end
            VCHK_SETTLE: begin
                if (settle_q == '0) begin
                    state_d     = VCHK_COMPARE;
                    cmp_valid_d = 1'b1;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            VCHK_COMPARE: begin
                if (mismatch) begin
                    cnt_inc = 1'b1;
                    if (!fail_seen_q) begin
                        fail_seen_d  = 1'b1;
                        first_fail_d = stim_q;
                    end
                end
                if (stim_q == STIM_LAST) begin
                    state_d = VCHK_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (mismatch_cnt == '0) && !mismatch;
                end else begin
                    stim_d  = stim_q + N_IN'(1);
                    state_d = VCHK_DRIVE;
                end
            end
            default: begin
                state_d = VCHK_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign stim           = stim_q;
    assign busy           = busy_q;
    assign cmp_valid      = cmp_valid_q;
    assign cmp_match      = cmp_valid_q && !mismatch;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_seen      = fail_seen_q;
    assign first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_vec_sweep_checker.sv
// Directed scoreboard bench for vec_sweep_checker: default instance plus a
// small-counter instance for saturation.
module tb_vec_sweep_checker;
    import vec_chk_pkg::*;

    typedef struct packed {
        logic [1:0] vec;
        logic       match;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_sat;
    int          mode;

    logic [1:0]  stim;
    logic        golden_in, netlist_in;
    logic        busy, cmp_valid, cmp_match, done, pass, fail_seen;
    logic [15:0] mismatch_cnt;
    logic [1:0]  first_fail_vec;

    logic [2:0]  stim_s;
    logic        golden_s, netlist_s;
    logic        busy_s, cmp_valid_s, cmp_match_s, done_s, pass_s, fail_seen_s;
    logic [1:0]  mismatch_cnt_s;
    logic [2:0]  first_fail_vec_s;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    assign golden_in  = stim[0] ^ stim[1];
    assign netlist_in = golden_in ^ ((mode == 2) || (mode == 1 && stim == 2'b11));
    assign golden_s   = stim_s[0];
    assign netlist_s  = ~stim_s[0];

    vec_sweep_checker u_dut (
        .clk(clk), .rst(rst), .start(start), .stim(stim),
        .golden_in(golden_in), .netlist_in(netlist_in),
        .busy(busy), .cmp_valid(cmp_valid), .cmp_match(cmp_match),
        .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
        .fail_seen(fail_seen), .first_fail_vec(first_fail_vec)
    );

    vec_sweep_checker #(.N_IN(3), .N_OUT(1), .SETTLE_CYC(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start_sat), .stim(stim_s),
        .golden_in(golden_s), .netlist_in(netlist_s),
        .busy(busy_s), .cmp_valid(cmp_valid_s), .cmp_match(cmp_match_s),
        .done(done_s), .pass(pass_s), .mismatch_cnt(mismatch_cnt_s),
        .fail_seen(fail_seen_s), .first_fail_vec(first_fail_vec_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Full default sweep; optionally re-pulses start during the first SETTLE.
    task automatic run_sweep(input int mode_in, input bit repulse,
                             input int exp_cnt, input int exp_first);
        int   nbusy;
        int   npulse;
        exp_t e;
        mode = mode_in;
        for (int v = 0; v < 4; v++) begin
            e.vec   = 2'(v);
            e.match = !((mode_in == 2) || (mode_in == 1 && v == 3));
            sb_q.push_back(e);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("start_done_low", 32'(done), 32'd0);
        chk("start_busy",     32'(busy), 32'd1);
        chk("start_cnt_clr",  32'(mismatch_cnt), 32'd0);
        chk("start_fail_clr", 32'(fail_seen), 32'd0);
        chk("start_stim",     32'(stim), 32'd0);
        nbusy  = 0;
        npulse = 0;
        for (int c = 0; c < int'(vchk_sweep_cycles(2, 2)) + 8; c++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (cmp_valid) begin
                npulse++;
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("cmp_vec",   32'(stim), 32'(e.vec));
                    chk("cmp_match", 32'(cmp_match), 32'(e.match));
                end
            end
            start = (repulse && nbusy == 2);
            if (done) break;
        end
        start = 1'b0;
        chk("sweep_done",   32'(done), 32'd1);
        chk("busy_cycles",  32'(nbusy), vchk_sweep_cycles(2, 2));
        chk("cmp_pulses",   32'(npulse), 32'd4);
        chk("sb_empty",     32'(sb_q.size()), 32'd0);
        chk("mismatch_cnt", 32'(mismatch_cnt), 32'(exp_cnt));
        chk("fail_seen",    32'(fail_seen), 32'(exp_cnt != 0));
        chk("pass",         32'(pass), 32'(exp_cnt == 0));
        if (exp_cnt != 0) chk("first_fail_vec", 32'(first_fail_vec), 32'(exp_first));
    endtask

    initial begin
        int nsat;
        bit hit;
        rst = 1'b1; start = 1'b0; start_sat = 1'b0; mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stim",  32'(stim), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_pass",  32'(pass), 32'd0);
        chk("rst_cnt",   32'(mismatch_cnt), 32'd0);
        chk("rst_valid", 32'(cmp_valid), 32'd0);
        rst = 1'b0;

        run_sweep(0, 1'b0, 0, 0);   // clean loopback
        run_sweep(1, 1'b0, 1, 3);   // single fault at 2'b11, restart from DONE
        run_sweep(2, 1'b0, 4, 0);   // total fault
        run_sweep(0, 1'b1, 0, 0);   // start re-pulse during SETTLE ignored

        // Abort a failing sweep with reset while stim == 2.
        mode = 2;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stim == 2'd2) begin hit = 1'b1; break; end
        end
        chk("reach_stim2", 32'(hit), 32'd1);
        chk("pre_rst_cnt", 32'(mismatch_cnt), 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_stim",  32'(stim), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(cmp_valid), 32'd0);
        chk("mid_rst_match", 32'(cmp_match), 32'd0);
        chk("mid_rst_done",  32'(done), 32'd0);
        chk("mid_rst_pass",  32'(pass), 32'd0);
        chk("mid_rst_cnt",   32'(mismatch_cnt), 32'd0);
        chk("mid_rst_fail",  32'(fail_seen), 32'd0);
        chk("mid_rst_first", 32'(first_fail_vec), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'(busy), 32'd0);
        run_sweep(0, 1'b0, 0, 0);

        // Saturation on the 3-input, 2-bit-counter instance.
        @(posedge clk); #1 start_sat = 1'b1;
        @(posedge clk); #1 start_sat = 1'b0;
        nsat = 0;
        for (int c = 0; c < int'(vchk_sweep_cycles(3, 2)) + 8; c++) begin
            @(negedge clk);
            if (cmp_valid_s) begin
                nsat++;
                chk("sat_cmp_match", 32'(cmp_match_s), 32'd0);
            end
            if (done_s) break;
        end
        chk("sat_done",  32'(done_s), 32'd1);
        chk("sat_pulses", 32'(nsat), 32'd8);
        chk("sat_cnt",   32'(mismatch_cnt_s), 32'd3);
        chk("sat_pass",  32'(pass_s), 32'd0);
        chk("sat_fail",  32'(fail_seen_s), 32'd1);
        chk("sat_first", 32'(first_fail_vec_s), 32'd0);
        chk("sat_stim_hold", 32'(stim_s), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
